// File: rtl/tile_sequencer.sv
// Tile sequencer: streams one tile of reference/query words into the aligner BRAMs,
// runs the aligner core, then advances the pointers by the deltas the core reports.
module tile_sequencer #(
    parameter int REF_LEN_WIDTH     = 16,
    parameter int QUERY_LEN_WIDTH   = 16,
    parameter int LOG_MAX_TILE_SIZE = 9,
    parameter int MARKER            = 506
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [REF_LEN_WIDTH-1:0]     total_ref_length,
    input  logic [QUERY_LEN_WIDTH-1:0]   total_query_length,
    output logic                         ref_rd_en,
    output logic [REF_LEN_WIDTH-3:0]     ref_rd_addr,
    input  logic [31:0]                  ref_rd_data,
    output logic                         query_rd_en,
    output logic [QUERY_LEN_WIDTH-3:0]   query_rd_addr,
    input  logic [31:0]                  query_rd_data,
    output logic                         ref_wr_en,
    output logic                         query_wr_en,
    output logic [LOG_MAX_TILE_SIZE-3:0] ref_addr_in,
    output logic [LOG_MAX_TILE_SIZE-3:0] query_addr_in,
    output logic [31:0]                  ref_bram_data_in,
    output logic [31:0]                  query_bram_data_in,
    output logic                         core_start,
    output logic                         core_rst,
    input  logic                         core_stop,
    output logic [1:0]                   ref_start_offset,
    output logic [1:0]                   query_start_offset,
    output logic [1:0]                   init_state,
    output logic                         last_tile,
    input  logic [REF_LEN_WIDTH-1:0]     ref_next_tile_addr,
    input  logic [QUERY_LEN_WIDTH-1:0]   query_next_tile_addr,
    input  logic [1:0]                   next_tile_init_state,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [15:0]                  tile_count
);
    localparam int KW = LOG_MAX_TILE_SIZE - 2;
    localparam logic [KW-1:0]              K_LAST       = KW'(MARKER / 4 - 1);
    localparam logic [REF_LEN_WIDTH-1:0]   REF_MARKER   = REF_LEN_WIDTH'(MARKER);
    localparam logic [QUERY_LEN_WIDTH-1:0] QUERY_MARKER = QUERY_LEN_WIDTH'(MARKER);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RUN, CRST, ADVANCE} state_t;

    state_t                       state_reg, state_next;
    logic [REF_LEN_WIDTH-1:0]     ref_pos_reg, ref_total_reg, ref_delta_reg;
    logic [QUERY_LEN_WIDTH-1:0]   query_pos_reg, query_total_reg, query_delta_reg;
    logic [KW-1:0]                k_reg, wr_addr_reg;
    logic                         wr_en_reg, last_tile_reg, done_reg, err_reg;
    logic [1:0]                   cap_state_reg, init_state_reg, ref_off_reg, query_off_reg;
    logic [15:0]                  tile_count_reg;

    logic [REF_LEN_WIDTH:0]       ref_sum;
    logic [QUERY_LEN_WIDTH:0]     query_sum;
    logic [REF_LEN_WIDTH-1:0]     ref_new, ref_total_sel, ref_pos_sel;
    logic [QUERY_LEN_WIDTH-1:0]   query_new, query_total_sel, query_pos_sel;
    logic                         last_next, no_progress, terminate;

    // Saturating pointer advance: a carry out clamps to all-ones.
    assign ref_sum   = {1'b0, ref_pos_reg} + {1'b0, ref_delta_reg};
    assign query_sum = {1'b0, query_pos_reg} + {1'b0, query_delta_reg};
    assign ref_new   = ref_sum[REF_LEN_WIDTH] ? '1 : ref_sum[REF_LEN_WIDTH-1:0];
    assign query_new = query_sum[QUERY_LEN_WIDTH] ? '1 : query_sum[QUERY_LEN_WIDTH-1:0];

    // last_tile is evaluated against the pointers the next LOAD will use.
    always_comb begin
        ref_total_sel   = (state_reg == IDLE) ? total_ref_length   : ref_total_reg;
        query_total_sel = (state_reg == IDLE) ? total_query_length : query_total_reg;
        ref_pos_sel     = (state_reg == IDLE) ? '0 : ref_new;
        query_pos_sel   = (state_reg == IDLE) ? '0 : query_new;
        last_next = (ref_pos_sel >= ref_total_sel) ||
                    ((ref_total_sel - ref_pos_sel) <= REF_MARKER) ||
                    (query_pos_sel >= query_total_sel) ||
                    ((query_total_sel - query_pos_sel) <= QUERY_MARKER);
    end

    assign no_progress = (ref_delta_reg == '0) && (query_delta_reg == '0) && !last_tile_reg;
    assign terminate   = last_tile_reg || (ref_new >= ref_total_reg) || (query_new >= query_total_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cfg_valid) state_next = LOAD;
            LOAD:    if (k_reg == K_LAST) state_next = DRAIN;
            DRAIN:   state_next = RUN;
            RUN:     if (core_stop) state_next = CRST;
            CRST:    state_next = ADVANCE;
            ADVANCE: state_next = (no_progress || terminate) ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            ref_pos_reg     <= '0;
            query_pos_reg   <= '0;
            ref_total_reg   <= '0;
            query_total_reg <= '0;
            ref_delta_reg   <= '0;
            query_delta_reg <= '0;
            k_reg           <= '0;
            wr_addr_reg     <= '0;
            wr_en_reg       <= 1'b0;
            last_tile_reg   <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
            cap_state_reg   <= '0;
            init_state_reg  <= 2'd3;
            ref_off_reg     <= '0;
            query_off_reg   <= '0;
            tile_count_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            // BRAM write trails the read by the one-cycle read latency.
            wr_en_reg   <= (state_reg == LOAD);
            wr_addr_reg <= k_reg;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            case (state_reg)
                IDLE: if (cfg_valid) begin
                    ref_total_reg   <= total_ref_length;
                    query_total_reg <= total_query_length;
                    ref_pos_reg     <= '0;
                    query_pos_reg   <= '0;
                    init_state_reg  <= 2'd3;
                    tile_count_reg  <= '0;
                    ref_off_reg     <= '0;
                    query_off_reg   <= '0;
                    last_tile_reg   <= last_next;
                    k_reg           <= '0;
                end
                LOAD: k_reg <= (k_reg == K_LAST) ? '0 : k_reg + 1'b1;
                RUN: if (core_stop) begin
                    ref_delta_reg   <= ref_next_tile_addr;
                    query_delta_reg <= query_next_tile_addr;
                    cap_state_reg   <= next_tile_init_state;
                end
                ADVANCE: begin
                    ref_pos_reg    <= ref_new;
                    query_pos_reg  <= query_new;
                    init_state_reg <= cap_state_reg;
                    tile_count_reg <= tile_count_reg + 16'd1;
                    if (no_progress) begin
                        done_reg <= 1'b1;
                        err_reg  <= 1'b1;
                    end else if (terminate) begin
                        done_reg <= 1'b1;
                    end else begin
                        ref_off_reg   <= ref_new[1:0];
                        query_off_reg <= query_new[1:0];
                        last_tile_reg <= last_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cfg_ready          = (state_reg == IDLE);
    assign busy               = (state_reg != IDLE);
    assign ref_rd_en          = (state_reg == LOAD);
    assign query_rd_en        = (state_reg == LOAD);
    assign ref_rd_addr        = ref_pos_reg[REF_LEN_WIDTH-1:2] + {{(REF_LEN_WIDTH-2-KW){1'b0}}, k_reg};
    assign query_rd_addr      = query_pos_reg[QUERY_LEN_WIDTH-1:2] + {{(QUERY_LEN_WIDTH-2-KW){1'b0}}, k_reg};
    assign ref_wr_en          = wr_en_reg;
    assign query_wr_en        = wr_en_reg;
    assign ref_addr_in        = wr_addr_reg;
    assign query_addr_in      = wr_addr_reg;
    assign ref_bram_data_in   = ref_rd_data;
    assign query_bram_data_in = query_rd_data;
    assign core_start         = (state_reg == RUN);
    // The aligner is held in reset whenever the sequencer itself is.
    assign core_rst           = !rst_n || (state_reg == CRST);
    assign ref_start_offset   = ref_off_reg;
    assign query_start_offset = query_off_reg;
    assign init_state         = init_state_reg;
    assign last_tile          = last_tile_reg;
    assign done               = done_reg;
    assign err                = err_reg;
    assign tile_count         = tile_count_reg;
endmodule

// File: tb/tb_tile_sequencer.sv
// Randomized scoreboard bench for tile_sequencer: a job-level reference model queues expected
// BRAM writes, tile configurations and completions; a negedge monitor pops and compares them.
module tb_tile_sequencer;
    localparam int MARKER_C = 506;
    localparam int WORDS    = MARKER_C / 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid, cfg_ready;
    logic [15:0] total_ref_length, total_query_length;
    logic        ref_rd_en, query_rd_en;
    logic [13:0] ref_rd_addr, query_rd_addr;
    logic [31:0] ref_rd_data = '0, query_rd_data = '0;
    logic        ref_wr_en, query_wr_en;
    logic [6:0]  ref_addr_in, query_addr_in;
    logic [31:0] ref_bram_data_in, query_bram_data_in;
    logic        core_start, core_rst, core_stop;
    logic [1:0]  ref_start_offset, query_start_offset, init_state;
    logic        last_tile;
    logic [15:0] ref_next_tile_addr, query_next_tile_addr;
    logic [1:0]  next_tile_init_state;
    logic        busy, done, err;
    logic [15:0] tile_count;

    always #5 clk = ~clk;

    tile_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .total_ref_length(total_ref_length), .total_query_length(total_query_length),
        .ref_rd_en(ref_rd_en), .ref_rd_addr(ref_rd_addr), .ref_rd_data(ref_rd_data),
        .query_rd_en(query_rd_en), .query_rd_addr(query_rd_addr), .query_rd_data(query_rd_data),
        .ref_wr_en(ref_wr_en), .query_wr_en(query_wr_en),
        .ref_addr_in(ref_addr_in), .query_addr_in(query_addr_in),
        .ref_bram_data_in(ref_bram_data_in), .query_bram_data_in(query_bram_data_in),
        .core_start(core_start), .core_rst(core_rst), .core_stop(core_stop),
        .ref_start_offset(ref_start_offset), .query_start_offset(query_start_offset),
        .init_state(init_state), .last_tile(last_tile),
        .ref_next_tile_addr(ref_next_tile_addr), .query_next_tile_addr(query_next_tile_addr),
        .next_tile_init_state(next_tile_init_state),
        .busy(busy), .done(done), .err(err), .tile_count(tile_count)
    );

    typedef struct packed {logic [6:0] addr; logic [31:0] rdat; logic [31:0] qdat;} wr_t;
    typedef struct packed {logic [1:0] ro; logic [1:0] qo; logic [1:0] st; logic last;} tile_t;
    typedef struct packed {logic err; logic [15:0] tiles;} done_t;
    typedef struct packed {logic [15:0] dr; logic [15:0] dq; logic [1:0] st;} delta_t;

    wr_t    wq[$];
    tile_t  tq[$];
    done_t  dq[$];
    delta_t cq[$];

    int vectors = 0, miscompares = 0, done_seen = 0;
    bit hold_core = 1'b0;

    function automatic logic [31:0] mem_word(input int side, input int addr);
        logic [31:0] a;
        a = addr;
        return ((a * 32'h9E3779B1) ^ a) + ((side != 0) ? 32'h13572468 : 32'h0);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    // External word memories with one-cycle read latency.
    always @(posedge clk) begin
        if (ref_rd_en)   ref_rd_data   <= mem_word(0, int'(ref_rd_addr));
        if (query_rd_en) query_rd_data <= mem_word(1, int'(query_rd_addr));
    end

    // Reference model: walks a whole job tile by tile using the pointer rules directly.
    task automatic build_job(input int tr, input int tql, input int mode);
        int pr, pq, st, tiles, dr, dqd, ns;
        bit last;
        pr = 0; pq = 0; st = 3; tiles = 0;
        while (tiles < 200) begin
            last = ((tr - pr) <= MARKER_C) || ((tql - pq) <= MARKER_C);
            for (int k = 0; k < WORDS; k++)
                wq.push_back('{7'(k), mem_word(0, ((pr >> 2) + k) & 16'h3FFF),
                               mem_word(1, ((pq >> 2) + k) & 16'h3FFF)});
            tq.push_back('{2'(pr), 2'(pq), 2'(st), last});
            case (mode)
                1: begin dr = 500; dqd = (tiles == 0) ? 498 : 502; ns = (tiles == 0) ? 1 : 2; end
                2: begin dr = 0; dqd = 0; ns = 0; end
                3: begin dr = (tiles == 0) ? 256 : 65520; dqd = (tiles == 0) ? 256 : 16; ns = 3; end
                default: begin
                    dr  = $urandom_range(380, 506);
                    dqd = $urandom_range(380, 506);
                    ns  = $urandom_range(0, 3);
                    if ($urandom_range(0, 19) == 0) begin dr = 0; dqd = 0; end
                end
            endcase
            cq.push_back('{16'(dr), 16'(dqd), 2'(ns)});
            pr = (pr + dr > 65535) ? 65535 : pr + dr;
            pq = (pq + dqd > 65535) ? 65535 : pq + dqd;
            st = ns;
            tiles++;
            if (dr == 0 && dqd == 0 && !last) begin dq.push_back('{1'b1, 16'(tiles)}); return; end
            if (last || pr >= tr || pq >= tql) begin dq.push_back('{1'b0, 16'(tiles)}); return; end
        end
    endtask

    // Aligner core model: stops after a random run length; stray core_stop outside RUN.
    initial begin
        int run_cycles, stop_after;
        delta_t d;
        core_stop = 1'b0; ref_next_tile_addr = '0; query_next_tile_addr = '0;
        next_tile_init_state = '0; run_cycles = 0; stop_after = $urandom_range(1, 60);
        forever begin
            @(negedge clk);
            core_stop = 1'b0;
            if (rst_n && core_start) begin
                run_cycles++;
                if (!hold_core && run_cycles >= stop_after) begin
                    if (cq.size() == 0) begin flag("core_extra_tile"); d = '0; end
                    else d = cq.pop_front();
                    ref_next_tile_addr = d.dr; query_next_tile_addr = d.dq;
                    next_tile_init_state = d.st; core_stop = 1'b1;
                    run_cycles = 0; stop_after = $urandom_range(1, 60);
                end
            end else begin
                run_cycles = 0;
                if (rst_n && $urandom_range(0, 7) == 0) begin
                    core_stop = 1'b1;
                    ref_next_tile_addr = 16'($urandom); query_next_tile_addr = 16'($urandom);
                    next_tile_init_state = 2'($urandom);
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a write, a tile start or a done.
    initial begin
        int cyc, rd_pairs, rd_unpaired, crst_cycles, last_crst;
        bit prev_start;
        wr_t w; tile_t t; done_t e;
        cyc = 0; rd_pairs = 0; rd_unpaired = 0; crst_cycles = 0; last_crst = 0; prev_start = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_start = 0; rd_pairs = 0; rd_unpaired = 0; crst_cycles = 0;
            end else begin
                if (ref_rd_en && query_rd_en) rd_pairs++;
                else if (ref_rd_en || query_rd_en) rd_unpaired++;
                if (ref_wr_en || query_wr_en) begin
                    if (wq.size() == 0) flag("wr_unexpected");
                    else begin
                        w = wq.pop_front();
                        chk("wr_en_pair", {ref_wr_en, query_wr_en}, 2'b11);
                        chk("ref_wr_addr", ref_addr_in, w.addr);
                        chk("query_wr_addr", query_addr_in, w.addr);
                        chk("ref_wr_data", ref_bram_data_in, w.rdat);
                        chk("query_wr_data", query_bram_data_in, w.qdat);
                    end
                end
                if (core_start && !prev_start) begin
                    if (tq.size() == 0) flag("tile_unexpected");
                    else begin
                        t = tq.pop_front();
                        chk("tile_cfg", {ref_start_offset, query_start_offset, init_state, last_tile},
                            {t.ro, t.qo, t.st, t.last});
                        chk("rd_pairs", rd_pairs, WORDS);
                        chk("rd_unpaired", rd_unpaired, 0);
                    end
                    rd_pairs = 0; rd_unpaired = 0;
                end
                if (core_rst) begin crst_cycles++; last_crst = cyc; end
                if (err && !done) flag("err_without_done");
                if (done) begin
                    if (dq.size() == 0) flag("done_unexpected");
                    else begin
                        e = dq.pop_front();
                        chk("done_err", err, e.err);
                        chk("tile_count", tile_count, e.tiles);
                        chk("core_rst_cycles", crst_cycles, e.tiles);
                        chk("done_latency", cyc - last_crst, 2);
                        $display("job done: tiles=%0d err=%0b", tile_count, err);
                    end
                    crst_cycles = 0;
                    done_seen++;
                end
                prev_start = core_start;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_status"}, {cfg_ready, busy, done, err}, 4'b1000);
        chk({tag, "_enables"}, {ref_rd_en, query_rd_en, ref_wr_en, query_wr_en}, 4'b0000);
        chk({tag, "_core"}, {core_start, core_rst}, 2'b01);
        chk({tag, "_tilecfg"}, {ref_start_offset, query_start_offset, init_state, last_tile}, 7'b0000110);
        chk({tag, "_tile_count"}, tile_count, 0);
    endtask

    task automatic run_job(input int tr, input int tql, input int mode, input bit do_reset);
        int base, n, runc;
        $display("job start: ref_len=%0d query_len=%0d mode=%0d reset=%0b", tr, tql, mode, do_reset);
        build_job(tr, tql, mode);
        n = 0;
        while (!cfg_ready && n < 1000) begin @(negedge clk); n++; end
        @(negedge clk);
        cfg_valid = 1'b1; total_ref_length = 16'(tr); total_query_length = 16'(tql);
        base = done_seen;
        if (do_reset) hold_core = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        if (do_reset) begin
            runc = 0; n = 0;
            while (runc < 20 && n < 2000) begin @(negedge clk); n++; if (core_start) runc++; end
            chk("reset_run_reached", runc, 20);
            #2 rst_n = 1'b0;
            #1 check_reset_outputs("midrun_reset");
            wq.delete(); tq.delete(); dq.delete(); cq.delete();
            hold_core = 1'b0;
            repeat (2) @(negedge clk);
            chk("reset_no_done", done_seen, base);
            rst_n = 1'b1;
        end else begin
            n = 0;
            while (done_seen == base && n < 40000) begin
                @(negedge clk);
                n++;
                if (!cfg_ready && $urandom_range(0, 5) == 0) begin
                    cfg_valid = 1'b1;
                    total_ref_length = 16'($urandom); total_query_length = 16'($urandom);
                end else cfg_valid = 1'b0;
            end
            cfg_valid = 1'b0;
            if (done_seen == base) flag("job_timeout");
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; total_ref_length = '0; total_query_length = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("power_on");
        rst_n = 1'b1;
        run_job(400, 400, 0, 0);
        run_job(1000, 1000, 1, 0);
        run_job(1000, 1000, 2, 0);
        run_job(3000, 3000, 3, 0);
        run_job(506, 2000, 0, 0);
        run_job(507, 507, 0, 0);
        run_job(2000, 2000, 0, 1);
        run_job(1200, 1500, 0, 0);
        for (int j = 0; j < 8; j++)
            run_job($urandom_range(100, 3000), $urandom_range(100, 3000), 0, 0);
        repeat (5) @(negedge clk);
        chk("left_writes", wq.size(), 0);
        chk("left_tiles", tq.size(), 0);
        chk("left_dones", dq.size(), 0);
        chk("left_deltas", cq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tile_sequencer.md
TILE_SEQUENCER -- requirements
Module: tile_sequencer

Interface
REQ-001 Parameters SHALL be: REF_LEN_WIDTH, default 16, reference length/pointer width; QUERY_LEN_WIDTH, default 16, query length/pointer width; LOG_MAX_TILE_SIZE, default 9, log2 of tile capacity; MARKER, default 506, tile length in characters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 cfg_valid/cfg_ready  input/output  1/1  job handshake; total_ref_length (REF_LEN_WIDTH) and total_query_length (QUERY_LEN_WIDTH) are sampled when both are high.
REQ-005 ref_rd_en, ref_rd_addr  output  1, REF_LEN_WIDTH-2  external reference word read; ref_rd_data  input  32; fixed 1-cycle read latency, 4 chars/word, char i+0 in bits [7:0].
REQ-006 query_rd_en, query_rd_addr, query_rd_data  as REQ-005, query side.
REQ-007 ref_wr_en/query_wr_en  output  1; ref_addr_in/query_addr_in  output  LOG_MAX_TILE_SIZE-2; ref_bram_data_in/query_bram_data_in  output  32  aligner BRAM load port.
REQ-008 core_start  output  1; core_rst  output  1, active-high reset to aligner; core_stop  input  1.
REQ-009 ref_start_offset/query_start_offset  output  2; init_state  output  2; last_tile  output  1  aligner tile configuration.
REQ-010 ref_next_tile_addr (REF_LEN_WIDTH), query_next_tile_addr (QUERY_LEN_WIDTH), next_tile_init_state (2)  input  aligner tile result.
REQ-011 busy, done, err  output  1  status; done and err are 1-cycle pulses.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, DRAIN, RUN, CRST, ADVANCE; cfg_ready = 1 only in IDLE.
REQ-013 IDLE, cfg handshake: ref_pos = query_pos = 0, init_state = 3, tile_count = 0, go to LOAD.
REQ-014 LOAD: word counter k from 0 to W-1, W = MARKER/4 (126); read ref word (ref_pos>>2)+k and query word (query_pos>>2)+k, one each per cycle, both enables high for exactly W cycles.
REQ-015 Write side SHALL lag one cycle: wr_en high and BRAM addr = k, data = rd_data on the cycle after each read; DRAIN covers the final write, then RUN.
REQ-016 Offsets SHALL be ref_start_offset = ref_pos[1:0], query_start_offset = query_pos[1:0], stable from LOAD entry to ADVANCE.
REQ-017 last_tile SHALL be 1 when (total_ref_length - ref_pos) <= MARKER or (total_query_length - query_pos) <= MARKER, registered at LOAD entry.
REQ-018 RUN: core_start held high until the cycle core_stop = 1; in that cycle ref_next_tile_addr, query_next_tile_addr and next_tile_init_state SHALL be captured; next state CRST.
REQ-019 CRST: core_rst = 1 for exactly one cycle, core_start = 0; next ADVANCE.
REQ-020 ADVANCE: ref_pos += captured ref delta, query_pos += captured query delta, init_state = captured state, tile_count += 1.
REQ-021 Termination: if last_tile was 1, or new ref_pos >= total_ref_length, or new query_pos >= total_query_length, pulse done and go to IDLE; otherwise go to LOAD.
REQ-022 No-progress: both captured deltas zero and last_tile = 0 -> pulse err and done together, go to IDLE.
REQ-023 Pointer additions SHALL saturate at all-ones; no wrap-around.
REQ-024 Read addresses beyond the sequence end SHALL still be issued (padding is the aligner's concern); no early LOAD stop.
REQ-025 core_stop outside RUN SHALL be ignored; cfg_valid outside IDLE SHALL be ignored.
REQ-026 busy = 1 in all states except IDLE.

Reset
REQ-027 rst low SHALL asynchronously force IDLE; all enables, core_start, done, err, last_tile, offsets, counters and pointers = 0; init_state = 3; core_rst = 1 while rst low.
REQ-028 Reset mid-LOAD or mid-RUN SHALL abandon the job; no done pulse; cfg_ready = 1 on the first edge after release.

Verification
REQ-029 Lengths 400/400, core_stop after 50 cycles -> 126 paired reads, 126 writes addr 0..125, last_tile = 1, one core_rst pulse, done one cycle after ADVANCE, tile_count = 1.
REQ-030 Lengths 1000/1000, deltas 500/498 state 1, then 500/502 -> second tile reads from word 125, offsets ref 0, query 2, init_state = 1, done after tile 2.
REQ-031 Deltas 0/0 on a non-last tile -> err and done pulse together, no further LOAD.
REQ-032 rst low during RUN cycle 20 -> all outputs at reset values within the same cycle; new cfg accepted after release; clean run.
REQ-033 core_stop pulsed during LOAD, cfg_valid during RUN -> no effect; write count is still 126.
REQ-034 Deltas 0xFFF0 with ref_pos = 0x0100 -> ref_pos saturates at 0xFFFF, done asserted.
